// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmitter.
// Build option: UART_TX_PARITY_EN adds the PARITY state (8E1 frames).
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Width of an index that counts n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts CLKS_PER_BIT cycles, wraps on its own at the end
// of each period, and is held at zero while clear is high.
// bit_tick marks the last cycle of a period, pre_tick the cycle before it.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick,
  output logic pre_tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt;

  assign bit_tick = (cnt == CW'(CLKS_PER_BIT - 1));
  assign pre_tick = (cnt == CW'(CLKS_PER_BIT - 2));

  // Period counter; wrapping on bit_tick restarts timing at every state entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                cnt <= '0;
    else if (clear || bit_tick) cnt <= '0;
    else                       cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one start bit, DATA_BITS data bits LSB first, one stop bit.
// Build option: UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
// All outputs are registered. A start request still high on the last stop-bit
// cycle is taken on that edge, so back-to-back frames carry no idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);
  localparam int IW = idx_w(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [IW-1:0]        idx;
  logic                 bit_tick;
  logic                 pre_tick;
`ifdef UART_TX_PARITY_EN
  logic                 par;
`endif

  // Timer is parked at zero while idle so the start bit gets a full period.
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == IDLE),
    .bit_tick (bit_tick),
    .pre_tick (pre_tick)
  );

  // Frame sequencer, shift register and registered line/status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tx      <= IDLE_LEVEL;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      shreg   <= '0;
      idx     <= '0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          tx <= IDLE_LEVEL;
          if (start) begin
            shreg   <= data;
`ifdef UART_TX_PARITY_EN
            par     <= ^data;
`endif
            tx_busy <= 1'b1;
            tx      <= START_LEVEL;
            state   <= START;
          end
        end
        START: begin
          if (bit_tick) begin
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            idx   <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              tx    <= par;
              state <= PARITY;
`else
              tx    <= STOP_LEVEL;
              state <= STOP;
`endif
            end else begin
              tx    <= shreg[0];
              shreg <= shreg >> 1;
              idx   <= idx + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            tx    <= STOP_LEVEL;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          // Raise done so it lands exactly on the final stop-bit cycle.
          if (pre_tick) tx_done <= 1'b1;
          if (bit_tick) begin
            if (start) begin
              shreg <= data;
`ifdef UART_TX_PARITY_EN
              par   <= ^data;
`endif
              tx    <= START_LEVEL;
              state <= START;
            end else begin
              tx_busy <= 1'b0;
              tx      <= IDLE_LEVEL;
              state   <= IDLE;
            end
          end
        end
        default: begin
          tx_busy <= 1'b0;
          tx      <= IDLE_LEVEL;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4 with hand-computed frames.
// Honours UART_TX_PARITY_EN (adds the 8E1 frame check).
module tb_uart_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL   = NB * CPB;
  localparam int NCAP = 2 * FL + 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx_busy, tx_done, tx;

  int errors = 0;
  int checks = 0;

  logic [127:0] txv, bv, dv;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .data    (data),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch a frame and record tx/busy/done for NCAP cycles; cycle 1 follows
  // the acceptance edge. mode 0: pulse, 1: disturb while busy, 2: hold start.
  task automatic send(input logic [7:0] d, input int mode);
    txv = '0; bv = '0; dv = '0;
    data = d; start = 1'b1;
    @(posedge clk); #1;
    if (mode != 2) start = 1'b0;
    for (int k = 1; k <= NCAP; k++) begin
      txv[k] = tx; bv[k] = tx_busy; dv[k] = tx_done;
      if (mode == 1 && k == 10) begin data = ~d; start = 1'b1; end
      if (mode == 1 && k == 11) start = 1'b0;
      if (mode == 2 && k == FL + 1) start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Mid-period sample of bit b of a frame starting at cycle off+1.
  function automatic logic bit_at(input int off, input int b);
    return txv[off + b*CPB + 2];
  endfunction

  initial begin
    logic [9:0] exp_a5;
    logic [9:0] exp_0f;
    logic [7:0] dec;

    // Reset held low, then released
    repeat (3) @(posedge clk); #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_tx", 32'(tx), 32'd1);
    chk("post_rst_busy", 32'(tx_busy), 32'd0);

    // 8'hFF: start bit low 4 cycles, rest high, busy FL cycles, one done pulse
    send(8'hFF, 0);
    chk("ff_start_low", 32'($countones(txv[CPB:1])), 32'd0);
    chk("ff_ones", 32'($countones(txv[FL:1])), 32'(FL - CPB));
    chk("ff_busy_len", 32'($countones(bv[FL:1])), 32'(FL));
    chk("ff_busy_end", 32'(bv[FL+1]), 32'd0);
    chk("ff_done_cnt", 32'($countones(dv[NCAP:1])), 32'd1);
    chk("ff_done_pos", 32'(dv[FL]), 32'd1);
    chk("ff_idle_tx", 32'(txv[FL+1]), 32'd1);

    // 8'hA5: bits 0,1,0,1,0,0,1,0,1 then stop, bit i = exp_a5[i]
    exp_a5 = 10'b1101001010;
    send(8'hA5, 0);
    for (int b = 0; b < 9; b++) chk($sformatf("a5_bit%0d", b), 32'(bit_at(0, b)), 32'(exp_a5[b]));
    chk("a5_stop", 32'(bit_at(0, NB-1)), 32'd1);
`ifdef UART_TX_PARITY_EN
    chk("a5_parity", 32'(bit_at(0, 9)), 32'd0);
`endif

    // 8'h0F with data change and start pulse mid-frame: frame unchanged, no second frame
    exp_0f = 10'b1000011110;
    send(8'h0F, 1);
    for (int b = 0; b < 9; b++) chk($sformatf("dist_bit%0d", b), 32'(bit_at(0, b)), 32'(exp_0f[b]));
    chk("dist_busy_len", 32'($countones(bv[NCAP:1])), 32'(FL));
    chk("dist_done_cnt", 32'($countones(dv[NCAP:1])), 32'd1);

    // 8'h3C with start held: back-to-back frames, second start bit right after done
    send(8'h3C, 2);
    chk("b2b_done_cnt", 32'($countones(dv[2*FL:1])), 32'd2);
    chk("b2b_done1", 32'(dv[FL]), 32'd1);
    chk("b2b_done2", 32'(dv[2*FL]), 32'd1);
    chk("b2b_start2", 32'(txv[FL+1]), 32'd0);
    chk("b2b_busy_gap", 32'(bv[FL+1]), 32'd1);
    chk("b2b_busy_end", 32'(bv[2*FL+1]), 32'd0);
    dec = '0;
    for (int b = 1; b <= 8; b++) dec[b-1] = bit_at(FL, b);
    chk("b2b_data2", 32'(dec), 32'h3C);

`ifdef UART_TX_PARITY_EN
    // 8'h07: three ones -> parity 1, frame 44 cycles
    send(8'h07, 0);
    chk("par_bit", 32'(bit_at(0, 9)), 32'd1);
    chk("par_stop", 32'(bit_at(0, 10)), 32'd1);
    chk("par_len", 32'($countones(bv[NCAP:1])), 32'd44);
    chk("par_done", 32'(dv[44]), 32'd1);
`endif

    // Reset pulse mid-frame aborts immediately
    data = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk); #1;
    chk("mid_busy_pre", 32'(tx_busy), 32'd1);
    chk("mid_tx_pre", 32'(tx), 32'd0);
    reset = 1'b0; #1;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(tx_busy), 32'd0);
    chk("mid_rst_done", 32'(tx_done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (CPB * 3) @(posedge clk); #1;
    chk("after_rst_tx", 32'(tx), 32'd1);
    chk("after_rst_busy", 32'(tx_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
